// File: rtl/frame_deserializer_pkg.sv
// rtl/frame_deserializer_pkg.sv - shared constants for the serial frame receiver
// Contents: FSM state encoding and the line levels that mark frame start and stop.
package frame_deserializer_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam logic START_LEVEL = 1'b1;
  localparam logic STOP_LEVEL  = 1'b0;

endpackage

// File: rtl/frame_deserializer_sipo_reg.sv
// rtl/frame_deserializer_sipo_reg.sv - serial-in parallel-out shift register
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-high reset, clears q
//   shift_en  shift one bit in this edge
//   sin       serial bit entering at q[0]
//   q         parallel contents; the oldest bit ends up at q[WIDTH-1]
module sipo_reg import frame_deserializer_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/frame_deserializer.sv
// rtl/frame_deserializer.sv - recovers start/data/parity/stop framed words from a serial line
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high reset; discards any partial frame
//   sin         serial line, idles at 0
//   data_out    last word whose stop bit was good; held between frames
//   valid       one-cycle pulse, data_out updated
//   parity_err  one-cycle pulse alongside valid when parity mismatched
//   frame_err   one-cycle pulse when the stop bit was 1
//   busy        high while a frame is being received
module frame_deserializer import frame_deserializer_pkg::*; #(
  parameter int WIDTH      = 4,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sin,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic           PEN  = (PARITY_EN != 0);
  localparam logic           ODD  = (ODD_PARITY != 0);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic             pbit;
  logic [WIDTH-1:0] shreg;

  sipo_reg #(.WIDTH(WIDTH)) u_sipo (
    .clock    (clock),
    .reset    (reset),
    .shift_en (state == S_DATA),
    .sin      (sin),
    .q        (shreg)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      pbit       <= 1'b0;
      data_out   <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Status strobes live for exactly one cycle after the stop edge.
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sin == START_LEVEL) begin
            state <= S_DATA;
            count <= '0;
            busy  <= 1'b1;
          end
        end
        S_DATA: begin
          // Stop counting at the last bit so the counter never wraps.
          if (count == LAST) begin
            state <= PEN ? S_PARITY : S_STOP;
          end else begin
            count <= count + CW'(1);
          end
        end
        S_PARITY: begin
          pbit  <= sin;
          state <= S_STOP;
        end
        S_STOP: begin
          if (sin == STOP_LEVEL) begin
            data_out   <= shreg;
            valid      <= 1'b1;
            parity_err <= PEN & ((^shreg ^ pbit) != ODD);
          end else begin
            // A bad stop bit is not taken as the next start bit.
            frame_err <= 1'b1;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
